// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO, 8N1 LSB first; baud picked per frame from `choose`.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       choose,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_out,
  output logic             tx_busy,
  output logic [FIFO_AW:0] fifo_cnt
);

  localparam int unsigned DivSlow = CLK_HZ / 9600;
  localparam int unsigned CntW    = (DivSlow > 1) ? $clog2(DivSlow) : 1;

  // Counters hold DIV-1 so the slowest divisor fits in CntW bits.
  localparam logic [CntW-1:0] Reload9600   = CntW'(CLK_HZ / 9600 - 1);
  localparam logic [CntW-1:0] Reload19200  = CntW'(CLK_HZ / 19200 - 1);
  localparam logic [CntW-1:0] Reload57600  = CntW'(CLK_HZ / 57600 - 1);
  localparam logic [CntW-1:0] Reload115200 = CntW'(CLK_HZ / 115200 - 1);

  localparam logic [FIFO_AW:0] FullCnt = {1'b1, {FIFO_AW{1'b0}}};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e              state_q, state_d;
  logic [CntW-1:0]     baud_cnt_q, baud_cnt_d;
  logic [CntW-1:0]     reload_q, reload_d, reload_sel;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic                tx_out_q, tx_out_d;
  logic                busy_q;
  logic [7:0]          mem [2**FIFO_AW];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    cnt_q;
  logic                push, pop, bit_end, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign fifo_empty = (cnt_q == '0);
  assign tx_ready   = (cnt_q != FullCnt);
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (baud_cnt_q == '0);

  assign tx_out   = tx_out_q;
  assign tx_busy  = busy_q;
  assign fifo_cnt = cnt_q;

  always_comb begin
    unique case (choose)
      2'b00: reload_sel = Reload9600;
      2'b01: reload_sel = Reload19200;
      2'b10: reload_sel = Reload57600;
      2'b11: reload_sel = Reload115200;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    reload_d   = reload_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (state_q != StIdle) begin
      baud_cnt_d = bit_end ? reload_q : baud_cnt_q - CntW'(1);
    end
    unique case (state_q)
      StIdle: pop = !fifo_empty;
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          pop     = !fifo_empty;
        end
      end
      default: state_d = StIdle;
    endcase
    // A pop always starts a frame; the baud code is captured only here.
    if (pop) begin
      state_d    = StStart;
      reload_d   = reload_sel;
      baud_cnt_d = reload_sel;
      shift_d    = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d   = ^mem[rd_ptr_q];
`endif
    end
  end

  always_comb begin
    unique case (state_q)
      StStart:  tx_out_d = 1'b0;
      StData:   tx_out_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_out_d = parity_q;
`endif
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      reload_q   <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      reload_q   <= reload_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= (state_q != StIdle) || !fifo_empty;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (push && !pop) begin
        cnt_q <= cnt_q + (FIFO_AW + 1)'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - (FIFO_AW + 1)'(1);
      end
    end
  end

endmodule
